// File: rtl/exp_operand_sequencer.sv
// exp_operand_sequencer: feeds the exponential engine one operand at a time.
// Operands are queued in a DEPTH-entry FIFO. Each operand runs through the
// sequence IDLE -> CLR -> START -> WAIT. The engine result is then held in a
// single-entry valid/ready slot.
// Optional feature macro: EXP_SEQ_TIMEOUT_EN. It aborts WAIT after TIMEOUT
// cycles and returns an error result.
module exp_operand_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [15:0]              in_x,
   output logic                     eng_clr,
   output logic                     eng_start,
   output logic [15:0]              eng_x,
   input  logic                     eng_done,
   input  logic [1:0]               eng_int,
   input  logic [15:0]              eng_frac,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               out_int,
   output logic [15:0]              out_frac,
   output logic [15:0]              out_x,
   output logic                     out_err,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLR   = 2'd1;
   localparam logic [1:0] S_START = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   logic [1:0]    state_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic [15:0]   fifo_mem [DEPTH];

   logic push;
   logic pop;
   logic slot_free;
   logic done_capture;
   logic abort_capture;
   logic capture;
   logic timeout_hit;

   // Ready depends only on the registered occupancy, so there is no ready-through path.
   assign in_ready  = (count_reg < (AW+1)'(DEPTH));
   assign push      = in_valid && in_ready;
   assign pop       = (state_reg == S_IDLE) && (count_reg != '0);
   assign slot_free = !out_valid || out_ready;

   assign done_capture  = (state_reg == S_WAIT) && eng_done && slot_free;
   assign abort_capture = (state_reg == S_WAIT) && !eng_done && timeout_hit && slot_free;
   assign capture       = done_capture || abort_capture;

   assign eng_clr   = (state_reg == S_CLR);
   assign eng_start = (state_reg == S_START);
   assign busy      = (state_reg != S_IDLE);
   assign count     = count_reg;

`ifdef EXP_SEQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_reg;

   // timer_reg holds the number of WAIT cycles already completed before the current one.
   assign timeout_hit = (timer_reg >= TW'(TIMEOUT - 1));

   // Count WAIT cycles; reset to zero whenever the sequencer is outside WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         timer_reg <= '0;
      else if (state_reg != S_WAIT)
         timer_reg <= '0;
      else if (!timeout_hit)
         timer_reg <= timer_reg + 1'b1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
`endif

   // Operand storage: a plain array without reset, written on push.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= in_x;
   end

   // FIFO pointers and occupancy. A push and a pop on the same edge cancel out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Sequencer FSM. The popped operand is latched into eng_x and holds until the next pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         eng_x     <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (pop) begin
                  eng_x     <= fifo_mem[rd_ptr_reg];
                  state_reg <= S_CLR;
               end
            end
            S_CLR:   state_reg <= S_START;
            S_START: state_reg <= S_WAIT;
            S_WAIT: begin
               if (capture)
                  state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Result slot. A capture overwrites the slot; otherwise a handshake empties it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_int   <= '0;
         out_frac  <= '0;
         out_x     <= '0;
         out_err   <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_int   <= abort_capture ? 2'd0  : eng_int;
         out_frac  <= abort_capture ? 16'd0 : eng_frac;
         out_x     <= eng_x;
         out_err   <= abort_capture;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
